ip_wr_fifo_drain: RTL and testbench

Downstream stage of the AXI slave write channel. It queues each write command (write_req, write_addr_mem, write_byte_sz) and drains the matching beats from the write-data FIFO. Each beat becomes one valid/ready word write on the memory port, at an incrementing word address. It reports per-command completion and a sticky command-overflow error.

---
 rtl/ip_wr_drain_pkg.sv | 30 +++
 rtl/ip_wr_cmd_queue.sv | 57 +++++
 rtl/ip_wr_fifo_drain.sv | 149 ++++++++++++++
 tb/tb_ip_wr_fifo_drain.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_wr_drain_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ip_wr_drain_pkg : shared state encoding and sizing helpers. Rev 1.0
// ------------------------------------------------------------------
package ip_wr_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } drain_state_t;

  localparam int BSZ_W  = 13;
  localparam int BEAT_W = 14;

  function automatic int calc_bpb(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int calc_beat_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int calc_cmd_w(input int mem_addr_width);
    return mem_addr_width + BSZ_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ip_wr_cmd_queue.sv
`default_nettype none
// ------------------------------------------------------------------
// ip_wr_cmd_queue : synchronous command FIFO with FWFT head. Rev 1.0
// ------------------------------------------------------------------
module ip_wr_cmd_queue
  import ip_wr_drain_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = calc_cmd_w(25)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/ip_wr_fifo_drain.sv
`default_nettype none
// ------------------------------------------------------------------
// ip_wr_fifo_drain : drains write-data FIFO beats per queued command. Rev 1.0
// ------------------------------------------------------------------
module ip_wr_fifo_drain
  import ip_wr_drain_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int MEM_ADDR_WIDTH = 25,
  parameter int CMD_DEPTH      = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      write_req,
  input  logic [MEM_ADDR_WIDTH-1:0] write_addr_mem,
  input  logic [12:0]               write_byte_sz,
  input  logic                      fifo_empty,
  input  logic [DATA_WIDTH-1:0]     fifo_rdata,
  output logic                      fifo_pop,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      xfer_done,
  output logic                      busy,
  output logic                      cmd_overflow,
  input  logic                      err_clr
);

  localparam int BPB        = calc_bpb(DATA_WIDTH);
  localparam int BEAT_SHIFT = calc_beat_shift(DATA_WIDTH);
  localparam int CMD_W      = calc_cmd_w(MEM_ADDR_WIDTH);

  if ((DATA_WIDTH < 8) || (DATA_WIDTH > 1024) ||
      ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_data_width
    $error("ip_wr_fifo_drain: DATA_WIDTH must be a power of 2 in 8..1024");
  end
  if ((CMD_DEPTH < 2) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0)) begin : g_bad_cmd_depth
    $error("ip_wr_fifo_drain: CMD_DEPTH must be a power of 2, at least 2");
  end

  drain_state_t              r_state;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [BEAT_W-1:0]         r_beat_cnt;
  logic                      r_xfer_done;
  logic                      r_cmd_overflow;

  logic [CMD_W-1:0]          w_cmd_in;
  logic [CMD_W-1:0]          w_cmd_head;
  logic [MEM_ADDR_WIDTH-1:0] w_head_addr;
  logic [BSZ_W-1:0]          w_head_bsz;
  logic [BEAT_W-1:0]         w_beats;
  logic                      w_q_full;
  logic                      w_q_empty;
  logic                      w_q_pop;
  logic                      w_overflow;
  logic                      w_mem_valid;
  logic                      w_accept;

  assign w_cmd_in = {write_addr_mem, write_byte_sz};

  ip_wr_cmd_queue #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_queue (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (write_req),
    .i_wdata (w_cmd_in),
    .i_pop   (w_q_pop),
    .o_rdata (w_cmd_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  assign w_head_addr = w_cmd_head[CMD_W-1:BSZ_W];
  assign w_head_bsz  = w_cmd_head[BSZ_W-1:0];

  // Round-up division by bytes-per-beat; 14 bits keeps the carry of the add.
  assign w_beats = ({1'b0, w_head_bsz} + BEAT_W'(BPB - 1)) >> BEAT_SHIFT;

  assign w_q_pop     = (r_state == ST_LOAD);
  assign w_overflow  = write_req & w_q_full & ~w_q_pop;
  assign w_mem_valid = (r_state == ST_XFER) & ~fifo_empty;
  assign w_accept    = w_mem_valid & mem_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_beat_cnt  <= '0;
      r_xfer_done <= 1'b0;
    end else begin
      r_xfer_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_q_empty) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_addr     <= w_head_addr;
          r_beat_cnt <= w_beats;
          if (w_beats == '0) begin
            r_state     <= ST_DONE;
            r_xfer_done <= 1'b1;
          end else begin
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_accept) begin
            r_addr     <= r_addr + 1'b1;
            r_beat_cnt <= r_beat_cnt - 1'b1;
            if (r_beat_cnt == BEAT_W'(1)) begin
              r_state     <= ST_DONE;
              r_xfer_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // A dropped command outranks a simultaneous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_overflow <= 1'b0;
    end else if (w_overflow) begin
      r_cmd_overflow <= 1'b1;
    end else if (err_clr) begin
      r_cmd_overflow <= 1'b0;
    end
  end

  assign fifo_pop     = w_accept;
  assign mem_valid    = w_mem_valid;
  assign mem_addr     = r_addr;
  assign mem_wdata    = fifo_rdata;
  assign xfer_done    = r_xfer_done;
  assign busy         = (r_state != ST_IDLE) | ~w_q_empty;
  assign cmd_overflow = r_cmd_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ip_wr_fifo_drain.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ip_wr_fifo_drain : directed bench with a queue-based reference model. Rev 1.0
// ------------------------------------------------------------------
module tb_ip_wr_fifo_drain;

  localparam int DW = 64;
  localparam int AW = 25;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          write_req = 1'b0;
  logic [AW-1:0] write_addr_mem = '0;
  logic [12:0]   write_byte_sz = '0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_pop;
  logic          mem_valid;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          xfer_done;
  logic          busy;
  logic          cmd_overflow;
  logic          err_clr = 1'b0;

  always #5 clock = ~clock;

  ip_wr_fifo_drain #(
    .DATA_WIDTH     (DW),
    .MEM_ADDR_WIDTH (AW),
    .CMD_DEPTH      (4)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .write_req      (write_req),
    .write_addr_mem (write_addr_mem),
    .write_byte_sz  (write_byte_sz),
    .fifo_empty     (fifo_empty),
    .fifo_rdata     (fifo_rdata),
    .fifo_pop       (fifo_pop),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .xfer_done      (xfer_done),
    .busy           (busy),
    .cmd_overflow   (cmd_overflow),
    .err_clr        (err_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: FIFO contents, expected beat addresses, beats left per command.
  logic [DW-1:0] data_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            cmd_q[$];
  int            outstanding = 0;
  bit            done_due = 0;
  bit            pend_pop = 0;
  bit            prev_stall = 0;
  bit            exp_ovf = 0;
  bit            req_accept = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  int            n_acc = 0;
  int            n_done = 0;
  int            done_cyc = -1;
  logic [DW-1:0] next_word = 64'hA000_0000_0000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void refresh();
    fifo_empty = (data_q.size() == 0);
    fifo_rdata = (data_q.size() > 0) ? data_q[0] : '0;
  endfunction

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 0;
      pend_pop   = 0;
      done_due   = 0;
    end else begin
      chk("busy", busy, outstanding > 0);
      chk("cmd_overflow", cmd_overflow, exp_ovf);
      chk("fifo_pop", fifo_pop, mem_valid && mem_ready);
      if (mem_valid) begin
        chk("valid_while_empty", fifo_empty, 0);
        chk("mem_wdata", mem_wdata, fifo_rdata);
      end
      if (prev_stall) begin
        chk("stall_valid", mem_valid, 1);
        chk("stall_addr", mem_addr, prev_addr);
        chk("stall_data", mem_wdata, prev_data);
      end
      if (done_due) chk("xfer_done_after_last_beat", xfer_done, 1);
      done_due = 0;
      if (xfer_done) begin
        chk("xfer_done_expected", (cmd_q.size() > 0) && (cmd_q[0] == 0), 1);
        if ((cmd_q.size() > 0) && (cmd_q[0] == 0)) begin
          void'(cmd_q.pop_front());
          outstanding--;
          n_done++;
          done_cyc = cyc;
        end
      end
      if (mem_valid && mem_ready) begin
        chk("beat_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) chk("mem_addr", mem_addr, exp_addr_q.pop_front());
        if ((cmd_q.size() > 0) && (cmd_q[0] > 0)) begin
          cmd_q[0] = cmd_q[0] - 1;
          if (cmd_q[0] == 0) done_due = 1;
        end
        n_acc++;
      end
      prev_stall = mem_valid && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
      pend_pop   = fifo_pop;
      if (write_req && req_accept) outstanding++;
      if (write_req && !req_accept) exp_ovf = 1;
      else if (err_clr) exp_ovf = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (pend_pop) begin
      void'(data_q.pop_front());
      pend_pop = 0;
    end
    refresh();
  endtask

  task automatic push_data(input int n);
    for (int i = 0; i < n; i++) begin
      data_q.push_back(next_word);
      next_word = next_word + 64'h1111;
    end
    refresh();
  endtask

  task automatic issue(input logic [AW-1:0] a, input int bsz, input bit acc);
    write_req      = 1'b1;
    write_addr_mem = a;
    write_byte_sz  = 13'(bsz);
    req_accept     = acc;
    if (acc) begin
      int nb;
      nb = (bsz + 7) / 8;
      cmd_q.push_back(nb);
      for (int k = 0; k < nb; k++) exp_addr_q.push_back(AW'(a + k));
    end
    tick();
    write_req  = 1'b0;
    req_accept = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; (i < bound) && (busy || exp_addr_q.size() > 0); i++) tick();
    chk("drain_timeout", busy || exp_addr_q.size() > 0, 0);
  endtask

  task automatic wait_beats(input int base, input int n, input int bound);
    for (int i = 0; (i < bound) && (n_acc - base < n); i++) tick();
    chk("beat_wait_timeout", n_acc - base >= n, 1);
  endtask

  int c0;
  int a0;
  int d0;

  initial begin
    tick();
    tick();
    chk("rst_fifo_pop", fifo_pop, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_xfer_done", xfer_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_overflow", cmd_overflow, 0);
    reset_n = 1'b1;
    tick();

    // 32 bytes at 0x100, ready held high
    mem_ready = 1'b1;
    push_data(4);
    c0 = cyc; a0 = n_acc;
    issue(25'h100, 32, 1);
    wait_idle(30);
    chk("t1_done_latency", done_cyc - c0, 7);
    chk("t1_busy_drop", cyc - c0, 8);
    chk("t1_beats", n_acc - a0, 4);

    // 12 bytes -> 2 beats
    push_data(2);
    a0 = n_acc;
    issue(25'h2000, 12, 1);
    wait_idle(30);
    chk("t2_beats", n_acc - a0, 2);

    // zero-length command
    c0 = cyc; a0 = n_acc;
    issue(25'h3000, 0, 1);
    wait_idle(30);
    chk("t3_done_latency", done_cyc - c0, 3);
    chk("t3_beats", n_acc - a0, 0);

    // backpressure mid-burst
    push_data(4);
    a0 = n_acc;
    issue(25'h400, 32, 1);
    wait_beats(a0, 2, 30);
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stalled_valid", mem_valid, 1);
    end
    mem_ready = 1'b1;
    wait_idle(30);
    chk("t4_beats", n_acc - a0, 4);

    // FIFO runs dry during XFER
    push_data(1);
    a0 = n_acc;
    issue(25'h500, 24, 1);
    wait_beats(a0, 1, 30);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_dry_valid", mem_valid, 0);
    end
    push_data(2);
    wait_idle(30);
    chk("t5_beats", n_acc - a0, 3);

    // overflow: FSM stalled on a 1-beat command, 5 more requests
    mem_ready = 1'b0;
    push_data(7);
    d0 = n_done; a0 = n_acc;
    issue(25'h600, 8, 1);
    for (int i = 0; (i < 10) && !mem_valid; i++) tick();
    chk("t6_stall_reached", mem_valid, 1);
    issue(25'h700, 8, 1);
    issue(25'h710, 16, 1);
    issue(25'h720, 0, 1);
    issue(25'h730, 24, 1);
    err_clr = 1'b1;
    issue(25'h740, 8, 0);
    err_clr = 1'b0;
    chk("t6_overflow_set", cmd_overflow, 1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t6_overflow_clr", cmd_overflow, 0);
    mem_ready = 1'b1;
    wait_idle(100);
    chk("t6_done_count", n_done - d0, 5);
    chk("t6_beats", n_acc - a0, 7);

    // address wrap at the top of the word space
    push_data(2);
    a0 = n_acc;
    issue(25'h1FF_FFFF, 16, 1);
    wait_idle(30);
    chk("t7_beats", n_acc - a0, 2);

    // reset in the middle of a burst
    push_data(4);
    a0 = n_acc; d0 = n_done;
    issue(25'h50, 32, 1);
    wait_beats(a0, 2, 30);
    reset_n = 1'b0;
    #1;
    chk("t8_rst_fifo_pop", fifo_pop, 0);
    chk("t8_rst_mem_valid", mem_valid, 0);
    chk("t8_rst_mem_addr", mem_addr, 0);
    chk("t8_rst_xfer_done", xfer_done, 0);
    chk("t8_rst_busy", busy, 0);
    chk("t8_rst_cmd_overflow", cmd_overflow, 0);
    exp_addr_q.delete();
    cmd_q.delete();
    outstanding = 0;
    exp_ovf = 0;
    data_q.delete();
    refresh();
    tick();
    tick();
    reset_n = 1'b1;
    push_data(2);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t8_post_rst_valid", mem_valid, 0);
    end
    chk("t8_no_done", n_done - d0, 0);
    a0 = n_acc;
    issue(25'h10, 16, 1);
    wait_idle(30);
    chk("t8_resume_beats", n_acc - a0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
